router_sync: RTL and testbench
==============================

Name: router_sync

Overview:
- Synchronizer/steering stage between the router's input control FSM and the three per-port output FIFOs of the 1x3 router.
- Latches the 2-bit destination address from the packet header.
- Steers the FSM's single write strobe to the selected FIFO and returns that FIFO's full flag.
- Drives per-port valid_out and a per-port soft_reset that flushes a FIFO whose destination has stopped reading.

Parameters:
- TIMEOUT, 30: consecutive unread-valid cycles before soft_reset fires; legal range 2..2^CNT_W.
- CNT_W, 5: width of each per-port timeout counter.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  synchronous, active-low reset
- detect_add  in  1  header byte present on data_in; latch address
- data_in  in  2  header bits [1:0] = destination port (0,1,2 valid; 3 invalid)
- write_enb_reg  in  1  FSM write strobe for the current byte
- read_enb_0/1/2  in  1 each  destination read strobes
- empty_0/1/2  in  1 each  FIFO empty flags
- full_0/1/2  in  1 each  FIFO full flags
- write_enb  out  3  one-hot FIFO write enables
- fifo_full  out  1  full flag of the addressed FIFO
- vld_out_0/1/2  out  1 each  data available to destination
- soft_reset_0/1/2  out  1 each  one-cycle FIFO flush pulse

Behaviour:
- Address register addr[1:0]
  - Resets to 2'b11 (invalid).
  - On a clock edge with detect_add=1, loads data_in.
  - Otherwise holds; holds across a packet until the next detect_add.
- write_enb (combinational)
  - Equals (1 << addr) when write_enb_reg=1 and addr<3.
  - Otherwise 3'b000.
  - Invalid address never writes any FIFO.
- fifo_full (combinational)
  - Equals full_addr for addr 0..2; 0 for addr 3.
- vld_out_x (combinational)
  - Equals ~empty_x.
  - During reset the FIFOs report empty, so it is 0.
- Timeout counter per port x, width CNT_W, reset 0
  - Stall = vld_out_x & ~read_enb_x.
  - Stall=0: counter <= 0, soft_reset_x <= 0.
  - Stall=1 and counter < TIMEOUT-1: counter increments, soft_reset_x <= 0.
  - Stall=1 and counter == TIMEOUT-1: soft_reset_x <= 1, counter <= 0.
  - Result: soft_reset_x rises on the edge ending the TIMEOUT-th consecutive stall cycle.
  - Pulse width is exactly one cycle; a persisting stall re-fires every TIMEOUT cycles.
  - soft_reset_x is a registered output, reset value 0.
- Ports are independent; simultaneous timeouts on several ports pulse together.
- resetn=0 at any point clears addr, all counters and all soft_reset outputs on that edge; a timeout pending at reset never fires.
- detect_add and write_enb_reg in the same cycle: write_enb decodes the OLD addr. The new addr applies from the next cycle.

Optional Feature:
- Macro: ROUTER_SYNC_DROP_CNT_EN
- Defined:
  - Adds output drop_cnt[7:0], reset 0.
  - Increments (saturating at 255) once per cycle in which write_enb_reg=1 and addr==3, i.e. bytes dropped for an invalid address.
  - Cleared only by resetn.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package router_pkg:
  - NUM_PORTS=3
  - ADDR_W=2
  - ADDR_INVALID=2'b11
  - default TIMEOUT constant
- Sub-module router_sync_timer: one per port, parameterised by TIMEOUT/CNT_W.
  - Inputs clock, resetn, vld, rd; output soft_reset.
  - Instantiated three times.

Test Plan:
- Reset: resetn=0 for 2 cycles, then release with empty_x=1 -> write_enb=000, fifo_full=0, vld_out=000, soft_reset=000; write_enb_reg=1 before any detect_add -> write_enb=000.
- Steering: detect_add=1, data_in=01, then write_enb_reg=1 -> write_enb=010; set full_1=1, full_0=0 -> fifo_full=1; reload data_in=10 -> write_enb=100, fifo_full=full_2.
- Timeout: empty_0=0, read_enb_0=0 held -> soft_reset_0=1 on edge 30 only, 0 on edge 31, fires again on edge 60; a 29-cycle stall followed by read_enb_0=1 -> no pulse.
- Counter restart: stall port 1, pulse read_enb_1 at cycle 20 -> no pulse at 30; pulse at cycle 51 (30 stall cycles after the read).
- Invalid address: detect_add with data_in=11, write_enb_reg=1 for 5 cycles -> write_enb=000, fifo_full=0; with ROUTER_SYNC_DROP_CNT_EN, drop_cnt=5.
- Mid-operation reset and concurrency: stall ports 0 and 2 simultaneously -> both pulse on edge 30; repeat with resetn=0 at cycle 25 -> counters cleared, no pulse until 30 stall cycles after release.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and helpers for the 1x3 router synchronizer slice.
package router_pkg;

  localparam int unsigned NUM_PORTS   = 3;
  localparam int unsigned ADDR_W      = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // Default stall budget and matching counter width for the per-port timers
  localparam int unsigned TIMEOUT_DEF = 30;
  localparam int unsigned CNT_W_DEF   = 5;

  // One-hot decode of a destination address; invalid address yields all-zero
  function automatic logic [NUM_PORTS-1:0] addr_onehot(input logic [ADDR_W-1:0] addr,
                                                       input logic             en);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    if (en) begin
      case (addr)
        2'b00:   oh = 3'b001;
        2'b01:   oh = 3'b010;
        2'b10:   oh = 3'b100;
        default: oh = '0;
      endcase
    end
    return oh;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port stall timer: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles in which data is valid but the destination is not reading.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt;
  logic             stall;

  assign stall = vld & ~rd;

  // Count consecutive stall cycles; fire and restart on the TIMEOUT-th one
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!stall) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync.sv
// Steering stage between the router input FSM and the three output FIFOs:
// latches the header address, routes the write strobe, returns the addressed
// FIFO's full flag, and flushes FIFOs whose destination stops reading.
// Optional: define ROUTER_SYNC_DROP_CNT_EN to add drop_cnt, a saturating count
// of bytes written while the address is invalid.
module router_sync
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        detect_add,
  input  logic [1:0]  data_in,
  input  logic        write_enb_reg,
  input  logic        read_enb_0,
  input  logic        read_enb_1,
  input  logic        read_enb_2,
  input  logic        empty_0,
  input  logic        empty_1,
  input  logic        empty_2,
  input  logic        full_0,
  input  logic        full_1,
  input  logic        full_2,
  output logic [2:0]  write_enb,
  output logic        fifo_full,
  output logic        vld_out_0,
  output logic        vld_out_1,
  output logic        vld_out_2,
  output logic        soft_reset_0,
  output logic        soft_reset_1,
  output logic        soft_reset_2
`ifdef ROUTER_SYNC_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  logic [ADDR_W-1:0]    addr;
  logic [NUM_PORTS-1:0] vld;
  logic [NUM_PORTS-1:0] rd;
  logic [NUM_PORTS-1:0] srst;

  // Destination address, held for the whole packet until the next header
  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr <= ADDR_INVALID;
    end else if (detect_add) begin
      addr <= data_in;
    end
  end

  // Write steering decodes the registered address, so a header cycle still
  // uses the previous packet's destination
  always_comb begin
    write_enb = addr_onehot(addr, write_enb_reg);
  end

  // Full flag of the addressed FIFO; invalid address never reports full
  always_comb begin
    fifo_full = 1'b0;
    case (addr)
      2'b00:   fifo_full = full_0;
      2'b01:   fifo_full = full_1;
      2'b10:   fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign vld       = {~empty_2, ~empty_1, ~empty_0};
  assign rd        = {read_enb_2, read_enb_1, read_enb_0};
  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_timer
      router_sync_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
      ) u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld[gi]),
        .rd         (rd[gi]),
        .soft_reset (srst[gi])
      );
    end
  endgenerate

  assign soft_reset_0 = srst[0];
  assign soft_reset_1 = srst[1];
  assign soft_reset_2 = srst[2];

`ifdef ROUTER_SYNC_DROP_CNT_EN
  // Count bytes discarded because the header named no real port
  always_ff @(posedge clock) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else if (write_enb_reg && (addr == ADDR_INVALID) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: stimulus pushes hand-computed expectations
// into a queue; a monitor pops one entry per cycle on the falling edge.
module tb_router_sync;

  logic       clock;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
`ifdef ROUTER_SYNC_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  router_sync #(
    .TIMEOUT (30),
    .CNT_W   (5)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (read_enb_0),
    .read_enb_1    (read_enb_1),
    .read_enb_2    (read_enb_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .full_0        (full_0),
    .full_1        (full_1),
    .full_2        (full_2),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
`ifdef ROUTER_SYNC_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    bit         cwe;
    logic [2:0] we;
    bit         cff;
    logic       ff;
    bit         cvl;
    logic [2:0] vl;
    bit         csr;
    logic [2:0] sr;
    bit         cdr;
    logic [7:0] dr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   next_cdr = 1'b0;
  logic [7:0] next_dr = '0;
  bit   done = 1'b0;

  task automatic cmp(input string n, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.cwe) cmp({e.name, ".write_enb"}, {5'b0, write_enb}, {5'b0, e.we});
        if (e.cff) cmp({e.name, ".fifo_full"}, {7'b0, fifo_full}, {7'b0, e.ff});
        if (e.cvl) cmp({e.name, ".vld_out"}, {5'b0, vld_out_2, vld_out_1, vld_out_0}, {5'b0, e.vl});
        if (e.csr) cmp({e.name, ".soft_reset"}, {5'b0, soft_reset_2, soft_reset_1, soft_reset_0},
                       {5'b0, e.sr});
`ifdef ROUTER_SYNC_DROP_CNT_EN
        if (e.cdr) cmp({e.name, ".drop_cnt"}, drop_cnt, e.dr);
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Queue expectations for the current cycle, then advance one clock
  task automatic chk(input string n,
                     input bit cwe, input logic [2:0] we,
                     input bit cff, input logic ff,
                     input bit cvl, input logic [2:0] vl,
                     input bit csr, input logic [2:0] sr);
    exp_t e;
    e.name = n;
    e.cwe = cwe; e.we = we;
    e.cff = cff; e.ff = ff;
    e.cvl = cvl; e.vl = vl;
    e.csr = csr; e.sr = sr;
    e.cdr = next_cdr; e.dr = next_dr;
    next_cdr = 1'b0;
    exp_q.push_back(e);
    cyc();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  // Watchdog
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
    end
  end

  initial begin
    resetn = 1'b0; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
    cyc();
    cyc();
    chk("reset", 1, 3'b000, 1, 1'b0, 1, 3'b000, 1, 3'b000);
    resetn = 1'b1;
    chk("post_reset", 1, 3'b000, 1, 1'b0, 1, 3'b000, 1, 3'b000);

    // Write before any header: invalid address, no FIFO written
    write_enb_reg = 1'b1;
    chk("we_noaddr", 1, 3'b000, 1, 1'b0, 0, '0, 0, '0);

    // Header and write in the same cycle still use the old address
    detect_add = 1'b1; data_in = 2'b01;
    chk("we_old_addr", 1, 3'b000, 1, 1'b0, 0, '0, 0, '0);
    detect_add = 1'b0;
    chk("steer_p1", 1, 3'b010, 1, 1'b0, 0, '0, 0, '0);
    full_1 = 1'b1;
    chk("full_p1", 1, 3'b010, 1, 1'b1, 0, '0, 0, '0);
    full_1 = 1'b0; full_0 = 1'b1; full_2 = 1'b1;
    chk("full_other", 1, 3'b010, 1, 1'b0, 0, '0, 0, '0);

    detect_add = 1'b1; data_in = 2'b10;
    chk("reload_old", 1, 3'b010, 1, 1'b0, 0, '0, 0, '0);
    detect_add = 1'b0; data_in = 2'b00;
    chk("steer_p2", 1, 3'b100, 1, 1'b1, 0, '0, 0, '0);
    full_2 = 1'b0;
    chk("full_p2_clr", 1, 3'b100, 1, 1'b0, 0, '0, 0, '0);
    write_enb_reg = 1'b0;
    chk("we_idle", 1, 3'b000, 1, 1'b0, 0, '0, 0, '0);

    // Invalid address from a fresh reset
    do_reset();
    detect_add = 1'b1; data_in = 2'b11;
    full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
    next_cdr = 1'b1; next_dr = 8'd0;
    chk("inv_hdr", 1, 3'b000, 1, 1'b0, 0, '0, 0, '0);
    detect_add = 1'b0; write_enb_reg = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("inv_write", 1, 3'b000, 1, 1'b0, 0, '0, 0, '0);
    end
    write_enb_reg = 1'b0;
    next_cdr = 1'b1; next_dr = 8'd5;
    chk("inv_drop", 1, 3'b000, 1, 1'b0, 0, '0, 0, '0);
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

    // Port 0 continuous stall: pulse after edge 30 and edge 60
    empty_0 = 1'b0; read_enb_0 = 1'b0;
    for (int i = 0; i <= 61; i++) begin
      chk("to_p0", 0, '0, 0, 1'b0, 1, 3'b001, 1, (i == 30 || i == 60) ? 3'b001 : 3'b000);
    end
    empty_0 = 1'b1;
    chk("to_p0_stop", 0, '0, 0, 1'b0, 1, 3'b000, 1, 3'b000);

    // 29-cycle stall then a read: no pulse
    empty_0 = 1'b0;
    for (int i = 0; i < 29; i++) begin
      chk("short_p0", 0, '0, 0, 1'b0, 0, '0, 1, 3'b000);
    end
    read_enb_0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("short_p0_rd", 0, '0, 0, 1'b0, 0, '0, 1, 3'b000);
    end
    read_enb_0 = 1'b0; empty_0 = 1'b1;
    chk("short_p0_end", 0, '0, 0, 1'b0, 1, 3'b000, 1, 3'b000);

    // Port 1 restart: read at cycle 20, pulse 30 stalls later
    empty_1 = 1'b0;
    for (int i = 0; i <= 55; i++) begin
      read_enb_1 = (i == 20);
      chk("restart_p1", 0, '0, 0, 1'b0, 1, 3'b010, 1, (i == 51) ? 3'b010 : 3'b000);
    end
    read_enb_1 = 1'b0; empty_1 = 1'b1;
    chk("restart_end", 0, '0, 0, 1'b0, 1, 3'b000, 1, 3'b000);

    // Ports 0 and 2 together
    empty_0 = 1'b0; empty_2 = 1'b0;
    for (int i = 0; i <= 31; i++) begin
      chk("conc", 0, '0, 0, 1'b0, 1, 3'b101, 1, (i == 30) ? 3'b101 : 3'b000);
    end
    empty_0 = 1'b1; empty_2 = 1'b1;
    chk("conc_stop", 0, '0, 0, 1'b0, 1, 3'b000, 1, 3'b000);

    // Same, with reset after 25 stall edges
    empty_0 = 1'b0; empty_2 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      chk("pre_rst", 0, '0, 0, 1'b0, 1, 3'b101, 1, 3'b000);
    end
    resetn = 1'b0;
    chk("mid_rst", 0, '0, 0, 1'b0, 0, '0, 1, 3'b000);
    resetn = 1'b1;
    for (int i = 0; i <= 31; i++) begin
      chk("post_rst", 0, '0, 0, 1'b0, 1, 3'b101, 1, (i == 30) ? 3'b101 : 3'b000);
    end
    empty_0 = 1'b1; empty_2 = 1'b1;

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(negedge clock);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
